// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - control codes, FSM states and decode helper for the N-bit ALU
package alu_pkg;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_MUL = 4'b1000;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    // MUL is only a legal code when the multiplier is built in
    function automatic logic ctl_legal(input logic [3:0] ctl, input logic mul_en);
        case (ctl)
            CTL_AND, CTL_OR, CTL_ADD, CTL_SUB, CTL_SLT, CTL_NOR: ctl_legal = 1'b1;
            CTL_MUL: ctl_legal = mul_en;
            default: ctl_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_nbit_seq_bit_slice.sv
// rtl/alu_nbit_seq_bit_slice.sv - one-bit ALU slice with invert, carry and less inputs
module alu_bit_slice (
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic       less,
    input  logic [1:0] op,
    output logic       carry_out,
    output logic       result,
    output logic       set
);

    logic aa;
    logic bb;
    logic sum;

    assign aa        = a ^ ainvert;
    assign bb        = b ^ binvert;
    assign sum       = aa ^ bb ^ carry_in;
    assign carry_out = (aa & bb) | (aa & carry_in) | (bb & carry_in);
    assign set       = sum;

    // op selects AND, OR, full-adder sum or the pass-through less bit
    always_comb begin
        result = 1'b0;
        case (op)
            2'b00: result = aa & bb;
            2'b01: result = aa | bb;
            2'b10: result = sum;
            2'b11: result = less;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_nbit_seq.sv
// rtl/alu_nbit_seq.sv - registered N-bit rippled ALU with SLT, flags and shift-add MUL
module alu_nbit_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctl,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             ainvert;
    logic             bnegate;
    logic [1:0]       op;
    logic [WIDTH-1:0] slice_res;
    logic [WIDTH-1:0] slice_set;
    logic             msb_cin;
    logic             msb_cout;
    logic             slt_set;
    logic             unused_set;

    assign {ainvert, bnegate, op} = alu_ctl;

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_slice
        logic cin;
        logic cout;
        if (i == 0) begin : g_lsb
            assign cin = bnegate;
        end else begin : g_upper
            assign cin = g_slice[i-1].cout;
        end
        alu_bit_slice u_slice (
            .a        (a[i]),
            .b        (b[i]),
            .carry_in (cin),
            .ainvert  (ainvert),
            .binvert  (bnegate),
            .less     ((i == 0) ? slt_set : 1'b0),
            .op       (op),
            .carry_out(cout),
            .result   (slice_res[i]),
            .set      (slice_set[i])
        );
    end

    assign msb_cin    = g_slice[WIDTH-1].cin;
    assign msb_cout   = g_slice[WIDTH-1].cout;
    // sign of a-b corrected by overflow gives the true signed less-than
    assign slt_set    = slice_set[WIDTH-1] ^ (msb_cin ^ msb_cout);
    assign unused_set = ^slice_set[WIDTH-2:0];

    logic legal;
    logic is_mul;
    logic is_addsub;
    logic accept;

    assign legal     = ctl_legal(alu_ctl, MUL_EN);
    assign is_mul    = MUL_EN && (alu_ctl == CTL_MUL);
    assign is_addsub = (alu_ctl == CTL_ADD) || (alu_ctl == CTL_SUB);

    logic [WIDTH-1:0] sc_res;
    logic             sc_zero;
    logic             sc_carry;
    logic             sc_ovf;
    logic             sc_err;

    // single-cycle result and flags; illegal codes give zero result and only err
    always_comb begin
        sc_res   = '0;
        sc_zero  = 1'b0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_err   = 1'b0;
        if (!legal) begin
            sc_err = 1'b1;
        end else begin
            sc_res  = slice_res;
            sc_zero = (slice_res == '0);
            if (is_addsub) begin
                sc_carry = msb_cout;
                sc_ovf   = msb_cin ^ msb_cout;
            end
        end
    end

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] nxt_acc;
    logic [WIDTH-1:0] nxt_mpl;

    // {acc, mplier} is the running product; each step adds then shifts right
    assign mul_sum = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    assign nxt_acc = mul_sum[WIDTH:1];
    assign nxt_mpl = {mul_sum[0], mplier[WIDTH-1:1]};

    assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // control FSM, multiply iteration and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state     <= MUL;
                            mcand     <= a;
                            mplier    <= b;
                            acc       <= '0;
                            cnt       <= CW'(WIDTH);
                            out_valid <= 1'b0;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= sc_res;
                            result_hi <= '0;
                            zero      <= sc_zero;
                            carry_out <= sc_carry;
                            overflow  <= sc_ovf;
                            err       <= sc_err;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    if (flush) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end else begin
                        acc    <= nxt_acc;
                        mplier <= nxt_mpl;
                        cnt    <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state     <= IDLE;
                            out_valid <= 1'b1;
                            result    <= nxt_mpl;
                            result_hi <= nxt_acc;
                            zero      <= ({nxt_acc, nxt_mpl} == '0);
                            carry_out <= 1'b0;
                            overflow  <= |nxt_acc;
                            err       <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
